// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier with run-time signed/unsigned operands,
// valid/ready handshakes, zero-operand fast path and synchronous abort.
`timescale 1ns/1ps
module booth_seq_mult #(
    parameter int WIDTH     = 32,
    parameter int ZERO_SKIP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int EW = WIDTH + 1;
    localparam int PW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic          SKIP_EN  = (ZERO_SKIP != 32'sd0);

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        CALC_S = 2'd1,
        DONE_S = 2'd2
    } state_t;

    // One Booth iteration: add/subtract the multiplicand into the upper part,
    // then arithmetic-shift {upper, multiplier, q(-1)} right by one.
    function automatic logic [PW+EW:0] booth_step(
        input logic [PW-1:0] hi,
        input logic [EW-1:0] lo,
        input logic          qm1,
        input logic [EW-1:0] mcand
    );
        logic [PW-1:0] m_ext;
        logic [PW-1:0] sum;
        m_ext = {mcand[EW-1], mcand};
        case ({lo[0], qm1})
            2'b01:   sum = hi + m_ext;
            2'b10:   sum = hi - m_ext;
            default: sum = hi;
        endcase
        booth_step = {sum[PW-1], sum, lo};
    endfunction

    state_t                 state_r;
    state_t                 state_n;
    logic [PW-1:0]          acc_hi_r;
    logic [EW-1:0]          acc_lo_r;
    logic                   qm1_r;
    logic [EW-1:0]          mcand_r;
    logic [CW-1:0]          cnt_r;
    logic [2*WIDTH-1:0]     result_r;
    logic                   out_valid_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   zero_s;
    logic                   last_s;
    logic [EW-1:0]          ext_a_s;
    logic [EW-1:0]          ext_b_s;
    logic [PW+EW:0]         step_s;

    assign in_ready_s = en & reset & (state_r == IDLE_S);
    assign accept_s   = in_valid & in_ready_s & ~abort;
    assign zero_s     = SKIP_EN & ((inputA == {WIDTH{1'b0}}) | (inputB == {WIDTH{1'b0}}));
    assign last_s     = (cnt_r == CNT_ONE);
    assign step_s     = booth_step(acc_hi_r, acc_lo_r, qm1_r, mcand_r);

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign result     = result_r;

    // Operand extension to WIDTH+1 bits so the most negative value survives negation.
    always_comb begin
        ext_a_s = {1'b0, inputA};
        ext_b_s = {1'b0, inputB};
        if (signed_mode) begin
            ext_a_s = {inputA[WIDTH-1], inputA};
            ext_b_s = {inputB[WIDTH-1], inputB};
        end else begin
            ext_a_s = {1'b0, inputA};
            ext_b_s = {1'b0, inputB};
        end
    end

    // Next-state logic; abort outranks both accept and out_ready.
    always_comb begin
        state_n = state_r;
        if (en) begin
            case (state_r)
                IDLE_S: begin
                    if (accept_s) begin
                        state_n = zero_s ? DONE_S : CALC_S;
                    end else begin
                        state_n = IDLE_S;
                    end
                end
                CALC_S: begin
                    if (abort) begin
                        state_n = IDLE_S;
                    end else if (last_s) begin
                        state_n = DONE_S;
                    end else begin
                        state_n = CALC_S;
                    end
                end
                DONE_S: begin
                    if (abort || out_ready) begin
                        state_n = IDLE_S;
                    end else begin
                        state_n = DONE_S;
                    end
                end
                default: state_n = IDLE_S;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE_S;
        end else begin
            state_r <= state_n;
        end
    end

    // Accumulator, multiplier, multiplicand and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hi_r <= {PW{1'b0}};
            acc_lo_r <= {EW{1'b0}};
            qm1_r    <= 1'b0;
            mcand_r  <= {EW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (en) begin
            case (state_r)
                IDLE_S: begin
                    if (accept_s) begin
                        acc_hi_r <= {PW{1'b0}};
                        acc_lo_r <= ext_b_s;
                        qm1_r    <= 1'b0;
                        mcand_r  <= ext_a_s;
                        cnt_r    <= CNT_LOAD;
                    end
                end
                CALC_S: begin
                    if (!abort) begin
                        {acc_hi_r, acc_lo_r, qm1_r} <= step_s;
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; result only changes on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            result_r    <= {(2*WIDTH){1'b0}};
        end else if (en) begin
            out_valid_r <= (state_n == DONE_S);
            if ((state_r == CALC_S) && (state_n == DONE_S)) begin
                result_r <= step_s[2*WIDTH:1];
            end else if ((state_r == IDLE_S) && (state_n == DONE_S)) begin
                result_r <= {(2*WIDTH){1'b0}};
            end
        end
    end

endmodule
